fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Instruction fetch stage upstream of the decode/controller path. Owns the fetch PC, issues
//  word-addressed reads to instruction memory over a req/gnt + rvalid interface, and buffers
//  returned words with their PC in a DEPTH-entry prefetch queue. Presents them to decode with a
//  valid/ready handshake. A taken branch or jump (redirect) flushes the queue and in-flight reads.
// PARAMETERS
//  PCW       6   fetch PC / imem address width (word address, PC increments by 1)
//  DW        32  instruction width
//  DEPTH     4   prefetch queue entries; power of 2, >=2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk          in   1              clock, all state updates on rising edge
//  clr          in   1              synchronous active-high reset
//  imem_req     out  1              read request valid
//  imem_addr    out  PCW            read address (= fetch PC)
//  imem_gnt     in   1              memory accepts request this cycle (req & gnt = issued)
//  imem_rvalid  in   1              read data returned (in order, >=1 cycle after its gnt)
//  imem_rdata   in   DW             read data
//  redirect     in   1              taken branch/jump from controller
//  redirect_pc  in   PCW            new fetch target
//  ins_valid    out  1              queue head valid
//  ins          out  DW             queue head instruction
//  ins_pc       out  PCW            PC of queue head
//  ins_ready    in   1              decode consumes head (pop when ins_valid & ins_ready)
//  q_count      out  clog2(DEPTH)+1 entries currently in queue
// BEHAVIOUR
//  Reset (clr=1 at edge): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, q_count=0,
//   out_cnt=0, drop_cnt=0. While clr=1: imem_req=0, ins_valid=0. imem_addr=fetch_pc always.
//  Issue: imem_req = !clr & !redirect & (q_count + out_cnt < DEPTH) (registered values; a pop in
//   the same cycle is not credited). On req&gnt: fetch_pc<=fetch_pc+1 (mod 2^PCW), out_cnt+1.
//   Address is held stable while req=1 and gnt=0.
//  Response: on rvalid, out_cnt-1. If drop_cnt>0: word discarded, drop_cnt-1. Else word written to
//   queue tail with pc=resp_pc; resp_pc<=resp_pc+1 (mod 2^PCW). Simultaneous gnt and rvalid: net 0.
//  Output: first-word fall-through; ins/ins_pc/ins_valid driven from head registers, so a word
//   returned on cycle N is visible at ins on cycle N+1. Min latency gnt->ins_valid = 2 cycles.
//   Zero-wait memory with ins_ready=1 sustains 1 instruction/cycle.
//  Full/empty: credit rule guarantees no enqueue when full; pop when empty is ignored.
//   Simultaneous push+pop: q_count unchanged, order preserved.
//  Redirect (priority over all else): queue cleared (q_count=0 next cycle), any pop that cycle is
//   void; fetch_pc<=redirect_pc, resp_pc<=redirect_pc; imem_req=0 that cycle;
//   drop_cnt <= out_cnt - rvalid (all still-in-flight reads, including ones already dropping);
//   a word returning on the redirect cycle is discarded. Fetch resumes at redirect_pc next cycle.
//  Back-to-back redirects: last one wins; drop_cnt recomputed each time from out_cnt.
//  clr mid-operation: all state reset as above; imem must be reset by the same clr so no stale
//   rvalid arrives afterwards (rvalid with out_cnt=0 is a protocol error, word ignored).
// TESTING
//  1 clr=1 two cycles -> imem_req=0, ins_valid=0, q_count=0; after release imem_req=1, imem_addr=0.
//  2 gnt=1, rvalid 1 cycle later, rdata=0x1000_0000+addr, ins_ready=1 -> ins_pc 0,1,2,3.. one per
//    cycle, ins matches, no gaps after first word.
//  3 ins_ready=0 -> q_count reaches 4, imem_req drops once q_count+out_cnt=4; ins_ready=1 again ->
//    ins_pc continues 0,1,2,3,4.. with no loss or duplicate.
//  4 2-cycle read latency, redirect=1 redirect_pc=0x20 with 2 reads in flight -> both discarded,
//    q_count=0, next ins_valid shows ins_pc=0x20, ins=mem[0x20].
//  5 RESET_PC=62 streaming -> ins_pc 62,63,0,1; redirect on two consecutive cycles (0x10 then 0x30)
//    -> next delivered ins_pc=0x30.
//  6 clr asserted with queue at 3 and 1 read outstanding -> next cycle q_count=0, ins_valid=0,
//    imem_addr=RESET_PC; refetch delivers RESET_PC first.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch PC, credit-limited imem reads, FWFT prefetch queue
// Redirects flush the queue and count down in-flight reads so their words are dropped on return.
module fetch_prefetch_unit #(
  parameter int PCW      = 6,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     clr,
  output logic                     imem_req,
  output logic [PCW-1:0]           imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DW-1:0]            imem_rdata,
  input  logic                     redirect,
  input  logic [PCW-1:0]           redirect_pc,
  output logic                     ins_valid,
  output logic [DW-1:0]            ins,
  output logic [PCW-1:0]           ins_pc,
  input  logic                     ins_ready,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CSW = CW + 1;

  logic [PCW-1:0] fetch_pc;
  logic [PCW-1:0] resp_pc;
  logic [CW-1:0]  out_cnt;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  count;
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [DW-1:0]  q_data [DEPTH];
  logic [PCW-1:0] q_pc   [DEPTH];

  logic [CSW-1:0] credit_sum;
  logic           issue;
  logic           resp;
  logic           dropping;
  logic           push;
  logic           pop;

  // Credits count queued plus in-flight words, so every return always has a free slot.
  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, out_cnt};
    imem_req   = !clr && !redirect && (credit_sum < CSW'(DEPTH));
    issue      = imem_req && imem_gnt;
    resp       = imem_rvalid && (out_cnt != '0);
    dropping   = (drop_cnt != '0);
    push       = resp && !dropping && !redirect;
    ins_valid  = (count != '0) && !clr;
    pop        = ins_valid && ins_ready && !redirect;
  end

  assign imem_addr = fetch_pc;
  assign ins       = q_data[head];
  assign ins_pc    = q_pc[head];
  assign q_count   = count;

  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc <= PCW'(RESET_PC);
      resp_pc  <= PCW'(RESET_PC);
      out_cnt  <= '0;
      drop_cnt <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      // Every read still outstanding after this edge belongs to the abandoned path.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      out_cnt  <= out_cnt - CW'(resp);
      drop_cnt <= out_cnt - CW'(resp);
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + PCW'(1);
      end
      out_cnt <= out_cnt + CW'(issue) - CW'(resp);
      if (resp && dropping) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        tail    <= tail + AW'(1);
        resp_pc <= resp_pc + PCW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      q_data[tail] <= imem_rdata;
      q_pc[tail]   <= resp_pc;
    end
  end

endmodule
